fetch_npc_unit: RTL and testbench

//  Instruction-fetch stage of the MIPS core: owns the PC register and fetches

---
 rtl/mips_pkg.sv | 20 ++
 rtl/npc_calc.sv | 34 +++
 rtl/fetch_npc_unit.sv | 85 ++++++++
 tb/tb_fetch_npc_unit.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core front end.
//   NPC_* : next-PC select codes driven by the control unit (NPCOp)
//   fetch_state_t : fetch-stage FSM encoding
//   RESET_PC_DEFAULT : boot address loaded into the PC on reset
package mips_pkg;

   localparam logic [1:0] NPC_PC4 = 2'b00;  // sequential
   localparam logic [1:0] NPC_BR  = 2'b01;  // pc+4 relative branch
   localparam logic [1:0] NPC_J   = 2'b10;  // j/jal region jump
   localparam logic [1:0] NPC_JR  = 2'b11;  // jr/jalr register target

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      EXEC  = 2'd1,
      HALT  = 2'd2
   } fetch_state_t;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

endpackage

// File: rtl/npc_calc.sv
// Next-PC calculator (purely combinational).
//   pc_plus4  in  32  address of the instruction after the one in IR
//   ir_index  in  26  IR[25:0]; IR[15:0] doubles as the branch immediate
//   npc_op    in  2   next-PC select (see mips_pkg NPC_*)
//   reg_rs    in  32  register target for jr/jalr
//   next_pc   out 32  selected next PC, modulo 2^32
module npc_calc
   import mips_pkg::*;
(
   input  logic [31:0] pc_plus4,
   input  logic [25:0] ir_index,
   input  logic [1:0]  npc_op,
   input  logic [31:0] reg_rs,
   output logic [31:0] next_pc
);

   // Word-scaled, sign-extended branch displacement.
   function automatic logic signed [31:0] branch_offset(input logic [15:0] imm);
      branch_offset = {{14{imm[15]}}, imm, 2'b00};
   endfunction

   always_comb begin
      next_pc = pc_plus4;
      case (npc_op)
         NPC_PC4: next_pc = pc_plus4;
         NPC_BR:  next_pc = pc_plus4 + $unsigned(branch_offset(ir_index[15:0]));
         // Jumps stay inside the 256 MB region of the delay-slot address.
         NPC_J:   next_pc = {pc_plus4[31:28], ir_index, 2'b00};
         NPC_JR:  next_pc = reg_rs;
         default: next_pc = pc_plus4;
      endcase
   end

endmodule

// File: rtl/fetch_npc_unit.sv
// Instruction-fetch stage: owns the PC and IR, fetches over a req/ack
// handshake, presents the word to the decoder and commits the next PC.
//   clk, rst              clock, synchronous active-high reset
//   imem_req/addr         fetch request (held until ack) and address (= pc)
//   imem_ack/rdata        read data valid strobe and instruction word
//   instr, instr_valid    instruction register and its "executing" flag
//   pc, pc_plus4          address of IR and its link value
//   npc_op, reg_rs        next-PC select and register target, taken in EXEC
//   hold                  downstream stall, freezes EXEC
//   addr_err              sticky misaligned-target flag (only rst clears it)
module fetch_npc_unit
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic        instr_valid,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   input  logic [1:0]  npc_op,
   input  logic [31:0] reg_rs,
   input  logic        hold,
   output logic        addr_err
);

   fetch_state_t state, state_nxt;
   logic [31:0]  pc_q;
   logic [31:0]  ir_q;
   logic [31:0]  next_pc;
   logic         commit;

   npc_calc u_npc_calc (
      .pc_plus4 (pc_plus4),
      .ir_index (ir_q[25:0]),
      .npc_op   (npc_op),
      .reg_rs   (reg_rs),
      .next_pc  (next_pc)
   );

   assign pc_plus4  = pc_q + 32'd4;
   assign pc        = pc_q;
   assign imem_addr = pc_q;
   assign instr     = ir_q;

   // Outputs are masked while rst is high so the memory side never sees a
   // request in the reset cycle, even on the very first edge.
   assign imem_req    = (state == FETCH) && !rst;
   assign instr_valid = (state == EXEC) && !rst;
   assign addr_err    = (state == HALT);

   assign commit = (state == EXEC) && !hold;

   always_comb begin
      state_nxt = state;
      case (state)
         FETCH: if (imem_ack) state_nxt = EXEC;
         EXEC:  if (!hold) state_nxt = (next_pc[1:0] != 2'b00) ? HALT : FETCH;
         HALT:  state_nxt = HALT;
         default: state_nxt = FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= FETCH;
      else     state <= state_nxt;
   end

   // The misaligned target is still written to pc so it is visible for debug.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q <= RESET_PC;
         ir_q <= 32'd0;
      end else begin
         if ((state == FETCH) && imem_ack) ir_q <= imem_rdata;
         if (commit) pc_q <= next_pc;
      end
   end

endmodule

// File: tb/tb_fetch_npc_unit.sv
module tb_fetch_npc_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = 32'd0;
   logic [31:0] instr;
   logic        instr_valid;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic [1:0]  npc_op = 2'b00;
   logic [31:0] reg_rs = 32'd0;
   logic        hold = 1'b0;
   logic        addr_err;

   fetch_npc_unit #(.RESET_PC(32'h0000_3000)) dut (
      .clk         (clk),
      .rst         (rst),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .instr       (instr),
      .instr_valid (instr_valid),
      .pc          (pc),
      .pc_plus4    (pc_plus4),
      .npc_op      (npc_op),
      .reg_rs      (reg_rs),
      .hold        (hold),
      .addr_err    (addr_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] word;
   } exp_t;

   exp_t        exp_q[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   logic [31:0] model_pc = 32'h0000_3000;
   logic [31:0] model_ir = 32'd0;
   int          last_req_t = 0;
   int          last_req_cycles = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Architectural next-PC rule, written from the ISA description.
   function automatic logic [31:0] model_next(input logic [31:0] p, input logic [31:0] ir,
                                              input logic [1:0] op, input logic [31:0] rs);
      logic [31:0] seq;
      int          simm;
      seq  = p + 32'd4;
      simm = int'($signed(ir[15:0]));
      case (op)
         2'd0:    return seq;
         2'd1:    return seq + 32'(simm * 4);
         2'd2:    return (seq & 32'hF000_0000) | ({6'd0, ir[25:0]} << 2);
         default: return rs;
      endcase
   endfunction

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      imem_ack = 1'b0;
      hold = 1'b0;
      #1;
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_vld", {31'd0, instr_valid}, 32'd0);
      step();
      rst = 1'b0;
      #1;
      chk("rst_pc", pc, 32'h0000_3000);
      chk("rst_ir", instr, 32'd0);
      chk("rst_err", {31'd0, addr_err}, 32'd0);
      model_pc = 32'h0000_3000;
   endtask

   task automatic do_fetch(input logic [31:0] word, input int delay);
      int n;
      n = 0;
      while (!imem_req && n < 8) begin
         step();
         n++;
      end
      if (!imem_req) begin
         chk("fetch_timeout", {31'd0, imem_req}, 32'd1);
         return;
      end
      last_req_t = cyc;
      last_req_cycles = 0;
      chk("fetch_addr", imem_addr, model_pc);
      repeat (delay) begin
         imem_ack = 1'b0;
         imem_rdata = $urandom;
         if (imem_req) last_req_cycles++;
         step();
      end
      imem_ack = 1'b1;
      imem_rdata = word;
      if (imem_req) last_req_cycles++;
      exp_q.push_back('{pc: model_pc, word: word});
      model_ir = word;
      step();
      imem_ack = 1'b0;
      imem_rdata = $urandom;
   endtask

   task automatic do_exec(input logic [1:0] op, input logic [31:0] rs, input int hold_n,
                          output bit halted);
      logic [31:0] nxt;
      halted = 1'b0;
      chk("exec_vld", {31'd0, instr_valid}, 32'd1);
      repeat (hold_n) begin
         hold = 1'b1;
         npc_op = 2'($urandom);
         reg_rs = $urandom;
         imem_ack = 1'($urandom);
         imem_rdata = $urandom;
         step();
      end
      hold = 1'b0;
      imem_ack = 1'b0;
      npc_op = op;
      reg_rs = rs;
      nxt = model_next(model_pc, model_ir, op, rs);
      step();
      npc_op = 2'($urandom);
      reg_rs = $urandom;
      model_pc = nxt;
      chk("commit_pc", pc, model_pc);
      if (nxt[1:0] != 2'b00) begin
         halted = 1'b1;
         repeat (3) begin
            chk("halt_err", {31'd0, addr_err}, 32'd1);
            chk("halt_req", {31'd0, imem_req}, 32'd0);
            chk("halt_vld", {31'd0, instr_valid}, 32'd0);
            chk("halt_pc4", pc_plus4, nxt + 32'd4);
            imem_ack = 1'($urandom);
            step();
         end
         imem_ack = 1'b0;
      end
   endtask

   // Scoreboard monitor: every entry into EXEC must present the next expected
   // (pc, word) pair; while stalled the pair must not move.
   initial begin : monitor
      bit          vld_prev;
      logic [31:0] cur_pc, cur_ir;
      exp_t        e;
      vld_prev = 1'b0;
      cur_pc = 32'd0;
      cur_ir = 32'd0;
      forever begin
         @(posedge clk);
         #1;
         if (rst) begin
            vld_prev = 1'b0;
         end else begin
            chk("pc_plus4", pc_plus4, pc + 32'd4);
            if (instr_valid && !vld_prev) begin
               if (exp_q.size() == 0) begin
                  chk("sb_unexpected", {31'd0, instr_valid}, 32'd0);
               end else begin
                  e = exp_q.pop_front();
                  chk("sb_pc", pc, e.pc);
                  chk("sb_instr", instr, e.word);
                  cur_pc = e.pc;
                  cur_ir = e.word;
               end
            end else if (instr_valid) begin
               chk("hold_pc", pc, cur_pc);
               chk("hold_instr", instr, cur_ir);
            end
            vld_prev = instr_valid;
         end
      end
   end

   initial begin : driver
      bit          h;
      int          t0;
      logic [31:0] w, rs;
      logic [1:0]  op;

      // Test 1: back-to-back sequential fetches, one every two cycles.
      step();
      do_reset();
      do_fetch(32'd0, 0);
      t0 = last_req_t;
      do_exec(2'd0, 32'd0, 0, h);
      do_fetch(32'd0, 0);
      chk("t1_addr1", imem_addr, 32'h0000_3004);
      chk("t1_gap1", 32'(last_req_t - t0), 32'd2);
      t0 = last_req_t;
      do_exec(2'd0, 32'd0, 0, h);
      #1;
      chk("t1_addr2", imem_addr, 32'h0000_3008);
      do_fetch(32'd0, 0);
      chk("t1_gap2", 32'(last_req_t - t0), 32'd2);
      do_exec(2'd0, 32'd0, 0, h);

      // Test 2: backward branch from 0x3010.
      do_fetch(32'd0, 0);
      do_exec(2'd0, 32'd0, 0, h);
      chk("t2_pc", pc, 32'h0000_3010);
      do_fetch(32'h1000_FFFE, 0);
      do_exec(2'd1, 32'd0, 0, h);
      chk("t2_target", imem_addr, 32'h0000_300C);
      do_fetch(32'd0, 1);
      do_exec(2'd0, 32'd0, 0, h);

      // Test 3: region jump, then register jump.
      do_reset();
      do_fetch(32'h0800_0C10, 0);
      do_exec(2'd2, 32'd0, 0, h);
      chk("t3_j", imem_addr, 32'h0000_3040);
      do_fetch(32'h0000_0008, 0);
      do_exec(2'd3, 32'h0000_4000, 0, h);
      chk("t3_jr", imem_addr, 32'h0000_4000);

      // Test 4: slow memory and a stalled EXEC.
      do_fetch(32'h2108_0001, 3);
      chk("t4_req_cycles", 32'(last_req_cycles), 32'd4);
      chk("t4_req_low", {31'd0, imem_req}, 32'd0);
      do_exec(2'd0, 32'd0, 2, h);
      chk("t4_pc", pc, 32'h0000_4004);

      // Test 5: misaligned register target halts until reset.
      do_fetch(32'h0000_0008, 0);
      do_exec(2'd3, 32'h0000_4002, 0, h);
      chk("t5_halted", {31'd0, h}, 32'd1);
      do_reset();

      // Test 6: reset while a fetch is waiting for its ack.
      do_fetch(32'hDEAD_BEE0, 0);
      do_exec(2'd0, 32'd0, 0, h);
      step();
      step();
      chk("t6_pending", {31'd0, imem_req}, 32'd1);
      do_reset();
      do_fetch(32'd0, 0);
      chk("t6_restart", pc, 32'h0000_3000);
      do_exec(2'd0, 32'd0, 0, h);

      // Address wrap at the top of memory.
      do_fetch(32'd0, 0);
      do_exec(2'd3, 32'hFFFF_FFFC, 0, h);
      do_fetch(32'd0, 0);
      chk("wrap_pc4", pc_plus4, 32'd0);
      do_exec(2'd0, 32'd0, 0, h);
      chk("wrap_pc", pc, 32'd0);
      chk("wrap_err", {31'd0, addr_err}, 32'd0);

      // Randomized instruction stream.
      for (int i = 0; i < 150; i++) begin
         w  = $urandom;
         op = 2'($urandom);
         rs = $urandom & 32'hFFFF_FFFC;
         if ($urandom_range(0, 24) == 0) rs[1:0] = 2'($urandom_range(1, 3));
         do_fetch(w, $urandom_range(0, 3));
         do_exec(op, rs, $urandom_range(0, 2), h);
         if (h) do_reset();
      end

      step();
      chk("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
